// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding controller: tracks in-flight register writes in a
// DEPTH-slot scoreboard, raises load-use stalls, redirect flushes and EX forwarding selects.
module hazard_fwd_unit #(
  parameter int REG_ADDR_W    = 5,
  parameter int DEPTH         = 3,
  parameter int ALU_AVAIL     = 1,
  parameter int LOAD_AVAIL    = 2,
  parameter int REDIRECT_SLOT = 1,
  parameter int CNT_W         = 16,
  localparam int FWD_W        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_reg_write,
  input  logic [REG_ADDR_W-1:0] id_waddr,
  input  logic                  id_is_load,
  input  logic                  redirect,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [FWD_W-1:0]      fwd_sel_a,
  output logic [FWD_W-1:0]      fwd_sel_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // The oldest slot's load flag is never consulted, so only DEPTH-1 flags are kept.
  logic [DEPTH-1:0]      slot_valid_r;
  logic [DEPTH-2:0]      slot_load_r;
  logic [REG_ADDR_W-1:0] slot_waddr_r [DEPTH];
  logic [REG_ADDR_W-1:0] ex_rs_r;
  logic [REG_ADDR_W-1:0] ex_rt_r;
  logic                  ex_use_rs_r;
  logic                  ex_use_rt_r;
  logic [CNT_W-1:0]      stall_cnt_r;
  logic [CNT_W-1:0]      flush_cnt_r;

  logic [DEPTH-1:0]      valid_nxt_s;
  logic [DEPTH-2:0]      load_nxt_s;
  logic [REG_ADDR_W-1:0] waddr_nxt_s [DEPTH];
  logic                  id_alloc_s;
  logic                  issue_s;
  logic                  haz_rs_s;
  logic                  haz_rt_s;
  logic                  stall_s;
  logic [FWD_W-1:0]      fwd_a_s;
  logic [FWD_W-1:0]      fwd_b_s;

  // EX forwarding: scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    fwd_a_s = '0;
    fwd_b_s = '0;
    for (int j = DEPTH - 1; j >= 1; j--) begin
      if (slot_valid_r[j] && ex_use_rs_r && (ex_rs_r != '0) && (slot_waddr_r[j] == ex_rs_r)) begin
        fwd_a_s = FWD_W'(j);
      end else begin
        fwd_a_s = fwd_a_s;
      end
      if (slot_valid_r[j] && ex_use_rt_r && (ex_rt_r != '0) && (slot_waddr_r[j] == ex_rt_r)) begin
        fwd_b_s = FWD_W'(j);
      end else begin
        fwd_b_s = fwd_b_s;
      end
    end
  end

  // ID stall: the youngest matching producer decides whether its result is ready in time.
  always_comb begin
    haz_rs_s = 1'b0;
    haz_rt_s = 1'b0;
    for (int j = DEPTH - 2; j >= 0; j--) begin
      if (slot_valid_r[j] && id_use_rs && (id_rs != '0) && (slot_waddr_r[j] == id_rs)) begin
        haz_rs_s = ((j + 1) < (slot_load_r[j] ? LOAD_AVAIL : ALU_AVAIL));
      end else begin
        haz_rs_s = haz_rs_s;
      end
      if (slot_valid_r[j] && id_use_rt && (id_rt != '0) && (slot_waddr_r[j] == id_rt)) begin
        haz_rt_s = ((j + 1) < (slot_load_r[j] ? LOAD_AVAIL : ALU_AVAIL));
      end else begin
        haz_rt_s = haz_rt_s;
      end
    end
    stall_s = id_valid & ~redirect & (haz_rs_s | haz_rt_s);
  end

  // Scoreboard next state: redirect kills the wrong-path slots, stall injects a bubble.
  always_comb begin
    id_alloc_s     = id_valid & id_reg_write & (id_waddr != '0);
    issue_s        = id_valid & ~stall_s & ~redirect;
    waddr_nxt_s[0] = id_waddr;
    load_nxt_s[0]  = id_is_load;
    if (redirect) begin
      valid_nxt_s[0] = 1'b0;
    end else begin
      valid_nxt_s[0] = id_alloc_s & ~stall_s;
    end
    for (int i = 1; i < DEPTH; i++) begin
      waddr_nxt_s[i] = slot_waddr_r[i-1];
      if (redirect && (i <= REDIRECT_SLOT)) begin
        valid_nxt_s[i] = 1'b0;
      end else begin
        valid_nxt_s[i] = slot_valid_r[i-1];
      end
    end
    for (int i = 1; i < DEPTH - 1; i++) begin
      load_nxt_s[i] = slot_load_r[i-1];
    end
  end

  // State registers, frozen while enable is low.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      slot_valid_r <= '0;
      slot_load_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_waddr_r[i] <= '0;
      end
      ex_rs_r     <= '0;
      ex_rt_r     <= '0;
      ex_use_rs_r <= 1'b0;
      ex_use_rt_r <= 1'b0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else if (enable) begin
      slot_valid_r <= valid_nxt_s;
      slot_load_r  <= load_nxt_s;
      for (int i = 0; i < DEPTH; i++) begin
        slot_waddr_r[i] <= waddr_nxt_s[i];
      end
      ex_rs_r     <= id_rs;
      ex_rt_r     <= id_rt;
      ex_use_rs_r <= issue_s & id_use_rs;
      ex_use_rt_r <= issue_s & id_use_rt;
      if (stall_s && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (redirect && (flush_cnt_r != '1)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign stall       = stall_s;
  assign flush_if_id = redirect;
  assign flush_id_ex = redirect;
  assign fwd_sel_a   = fwd_a_s;
  assign fwd_sel_b   = fwd_b_s;
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard detection and forwarding controller for the 5-stage pipelined `cpu`. It tracks in-flight register writes in a depth-configurable scoreboard and produces four things: load-use stall requests, branch/jump redirect flushes, per-operand forwarding selects for the EX stage, and saturating stall/flush event counters. It generalises the fixed EX/ME/WB pipeline to any scoreboard depth, any result-availability stage and any redirect stage.

## Interface
- REG_ADDR_W, 5: register address width.
- DEPTH, 3: scoreboard slots; slot 0 = EX, slot 1 = ME, slot 2 = WB, and so on.
- ALU_AVAIL, 1: first slot index at which a non-load result can be forwarded.
- LOAD_AVAIL, 2: first slot index at which a load result can be forwarded.
- REDIRECT_SLOT, 1: slot index of the instruction that resolves taken branch/jump.
- CNT_W, 16: event counter width.
- Legal range: 1 <= ALU_AVAIL <= LOAD_AVAIL <= DEPTH-1; 0 <= REDIRECT_SLOT <= DEPTH-1.
- FWD_W = $clog2(DEPTH) (derived).

Ports:
- clk  in  1  clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- enable  in  1  global pipeline advance; low freezes all state.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs, id_rt  in  REG_ADDR_W  source register addresses in ID.
- id_use_rs, id_use_rt  in  1  the ID instruction actually reads that source.
- id_reg_write  in  1  the ID instruction writes the register file.
- id_waddr  in  REG_ADDR_W  resolved destination (after reg_dst mux).
- id_is_load  in  1  the ID instruction is a load.
- redirect  in  1  the instruction in REDIRECT_SLOT redirects the PC this cycle.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- flush_if_id  out  1  squash IF/ID at next edge.
- flush_id_ex  out  1  squash ID/EX at next edge.
- fwd_sel_a, fwd_sel_b  out  FWD_W  EX operand source: 0 = register file data, k = result of slot k.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Each slot holds {valid, waddr, is_load}. A slot is allocated only if id_valid & id_reg_write & id_waddr != 0. Register 0 never matches anything.
- EX source register: {ex_rs, ex_rt, ex_use_rs, ex_use_rt}, loaded from the ID fields.
- Match rule for source s against slot j: valid & use & waddr == s. The youngest match (smallest j) wins; older matches are ignored.
- Forwarding (EX consumer): compare ex_rs and ex_rt against slots 1..DEPTH-1. fwd_sel is the youngest matching index, or 0 if there is no match. Availability is guaranteed by the stall rule.
- Stall (ID consumer): compare id_rs and id_rt against slots 0..DEPTH-2. For the youngest match j, stall if j+1 < (is_load ? LOAD_AVAIL : ALU_AVAIL). stall additionally requires id_valid & !redirect.
- Flush: flush_if_id = flush_id_ex = redirect. Redirect has priority over stall.
- Next state, applied only when enable=1:
  - Normal: slot[0] <= ID entry; slot[i] <= slot[i-1]; EX source register <= ID fields.
  - Stall: slot[0] <= bubble (valid=0); EX source register <= cleared uses; slots 1.. shift normally.
  - Redirect: slots 0..REDIRECT_SLOT <= invalid; slot[REDIRECT_SLOT+1..] shift normally; EX source register cleared.
- Counters: stall_cnt +1 per enabled cycle with stall=1; flush_cnt +1 per enabled cycle with redirect=1. Both hold at all-ones.

## Timing
- stall, flush_* and fwd_sel_* are combinational in the same cycle. fwd_sel depends only on registered state; stall also depends on the ID inputs.
- Scoreboard update latency is 1 cycle. A load-use pair with default parameters stalls exactly 1 cycle.
- enable=0: no state change and counters hold; outputs remain combinationally valid.
- Reset, asynchronous at any time including mid-stall or mid-flush:
  - All slots invalid, EX uses cleared, counters 0.
  - Resulting outputs: stall=0, fwd_sel_a=fwd_sel_b=0, flush_* follow redirect.
- Stall and redirect in the same cycle: the redirect action is taken, stall=0, and only flush_cnt increments.

## Test plan
- ALU back-to-back (defaults): add r3 then sub r7,r3,r1. With sub in EX, fwd_sel_a=1, fwd_sel_b=0; stall never asserted.
- Load-use: lw r5 then add r6,r5,r5. stall=1 for exactly one cycle. Next cycle fwd_sel_a=fwd_sel_b=2, stall_cnt=1.
- Youngest wins: add r4, add r4, then or r8,r4,r0. fwd_sel_a=1, not 2; fwd_sel_b=0.
- r0 and unused sources: addi r0 followed by a reader of r0 gives no stall and fwd_sel=0. lw r5 followed by an instruction with id_use_rt=0 and rt=5 gives no stall.
- Redirect: load in slot 0 with a dependent instruction in ID, redirect=1 for one cycle. Required: stall=0, flush_if_id=flush_id_ex=1, slots 0..1 invalid next cycle, flush_cnt=1.
- Freeze/reset/saturation: enable=0 for 4 cycles holds slots and counters. arst_n pulsed during a stall gives all outputs 0 immediately. With CNT_W=2, five stalls leave stall_cnt=3.
